elastic_pipe: RTL and testbench

- Parametrised multi-stage pipeline register with a valid/ready handshake, bubble collapsing and synchronous flush.
- Generalised successor to the single enable flop. Replaces hand-chained enable flops between processor pipeline stages, for example the fetch-to-decode and memory-response paths.
- Enable is derived per stage from downstream backpressure rather than driven externally.
- Reports occupancy for debug and performance counters.

---
 rtl/util_pkg.sv | 9 +
 rtl/pipe_slot.sv | 34 +++
 rtl/elastic_pipe.sv | 72 +++++++
 tb/tb_elastic_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/util_pkg.sv
// Shared helpers for the pipeline slice.
// count_w: width of a counter that holds the range 0..n.
package util_pkg;

    function automatic int count_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One elastic pipeline stage: a valid bit plus a data register.
// Ports: clk/reset/flush control; adv enables the stage, up_valid/up_data
// come from the previous stage; valid/data are the held contents.
module pipe_slot #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             adv,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Data only loads under a valid upstream payload, so bubbles
    // passing through leave the data register untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= RESET_VALUE;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (adv) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/elastic_pipe.sv
// Multi-stage valid/ready pipeline register with bubble collapsing and flush.
// Ports: clk, reset, flush; in_valid/in_ready/in_data upstream;
// out_valid/out_ready/out_data downstream; occupancy = valid stage count.
module elastic_pipe
    import util_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              CW          = count_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    occupancy
);

    logic [DEPTH:0]   adv;
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];

    // A stage may advance when it is empty or the stage after it advances;
    // this chain is what lets bubbles collapse under backpressure.
    assign adv[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;

        assign adv[i] = !v[i] || adv[i+1];

        if (i == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_body
            assign up_v = v[i-1];
            assign up_d = d[i-1];
        end

        pipe_slot #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .adv      (adv[i]),
            .up_valid (up_v),
            .up_data  (up_d),
            .valid    (v[i]),
            .data     (d[i])
        );
    end

    assign in_ready  = adv[0] && !flush;
    assign out_valid = v[DEPTH-1] && !flush;
    assign out_data  = d[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + CW'(v[i]);
        end
    end

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed scoreboard bench for elastic_pipe (WIDTH=8, DEPTH=3).
// Accepted inputs are queued and compared when they leave the pipe.
module tb_elastic_pipe;

    localparam int         W  = 8;
    localparam int         D  = 3;
    localparam logic [7:0] RV = 8'hA5;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } ent_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    ent_t sb[$];
    int   tests   = 0;
    int   fails   = 0;
    int   cyc     = 0;
    bit   lat_chk = 1'b0;

    elastic_pipe #(
        .WIDTH       (W),
        .DEPTH       (D),
        .RESET_VALUE (RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample just after the inputs settle, score the transfers that the
    // coming edge will perform, then advance to the next falling edge.
    task automatic tick();
        logic fi;
        logic fo;
        ent_t e;
        #1;
        fi = in_valid && in_ready;
        fo = out_valid && out_ready;
        if (fo) begin
            if (sb.size() == 0) begin
                chk("spurious_out", {31'b0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_data", {24'b0, out_data}, {24'b0, e.data});
                if (lat_chk) chk("latency", cyc - e.cyc, D);
            end
        end
        if (reset || flush) sb.delete();
        else if (fi) sb.push_back('{in_data, cyc});
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] val);
        in_valid = 1'b1;
        in_data  = val;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {24'b0, out_data}, {24'b0, RV});
        chk("rst_occupancy", {30'b0, occupancy}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Back-to-back stream, fixed latency of DEPTH cycles.
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        chk("stream_drained", sb.size(), 32'd0);
        lat_chk = 1'b0;

        // Fill under backpressure; extra push must be refused.
        out_ready = 1'b0;
        push(8'h10);
        push(8'h11);
        push(8'h12);
        #1;
        chk("full_occupancy", {30'b0, occupancy}, 32'd3);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        chk("full_out_data", {24'b0, out_data}, 32'h10);
        in_valid = 1'b1;
        in_data  = 8'h13;
        tick();
        tick();
        in_valid = 1'b0;
        #1;
        chk("stall_out_data", {24'b0, out_data}, 32'h10);
        chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_occupancy", {30'b0, occupancy}, 32'd3);
        out_ready = 1'b1;
        repeat (4) tick();
        chk("hold_drained", sb.size(), 32'd0);
        chk("hold_occ_zero", {30'b0, occupancy}, 32'd0);

        // Full pipe with simultaneous in and out transfer.
        out_ready = 1'b0;
        push(8'h40);
        push(8'h41);
        push(8'h42);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h43;
        #1;
        chk("thru_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("thru_occupancy", {30'b0, occupancy}, 32'd3);
        repeat (4) tick();
        chk("thru_drained", sb.size(), 32'd0);

        // Bubble collapses forward while the output is stalled.
        out_ready = 1'b0;
        push(8'h20);
        tick();
        push(8'h21);
        #1;
        chk("bubble_occupancy", {30'b0, occupancy}, 32'd2);
        chk("bubble_in_ready", {31'b0, in_ready}, 32'd1);
        chk("bubble_out_valid", {31'b0, out_valid}, 32'd1);
        chk("bubble_out_data", {24'b0, out_data}, 32'h20);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("bubble_drained", sb.size(), 32'd0);

        // Flush a full pipe, then restart.
        out_ready = 1'b0;
        push(8'h50);
        push(8'h51);
        push(8'h52);
        flush = 1'b1;
        #1;
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("post_flush_occ", {30'b0, occupancy}, 32'd0);
        chk("post_flush_valid", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        push(8'h30);
        repeat (5) tick();
        chk("flush_restart", sb.size(), 32'd0);
        lat_chk = 1'b0;

        // Reset together with flush discards in-flight data.
        out_ready = 1'b0;
        push(8'h60);
        push(8'h61);
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        #1;
        chk("rf_out_data", {24'b0, out_data}, {24'b0, RV});
        chk("rf_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rf_occupancy", {30'b0, occupancy}, 32'd0);
        chk("rf_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
